// File: rtl/count_ones_sequencer.sv
// rtl/count_ones_sequencer.sv - multi-cycle chunked population counter
//
// count_ones: combinational popcount of one CHUNK-wide slice.
//   bits  in  [WIDTH]       slice to count
//   ones  out [clog2(W+1)]  number of set bits in the slice
//
// count_ones_sequencer: accepts a WIDTH-bit vector on an input handshake,
// counts it CHUNK_WIDTH bits per cycle through one count_ones instance,
// then holds the total on an output handshake.
//   clock         in               rising-edge clock
//   reset         in               asynchronous active-high reset
//   input_data    in  [WIDTH]      vector to count, sampled on handshake
//   input_valid   in               upstream has data
//   input_ready   out              idle and able to accept a vector
//   output_count  out [COUNT_WIDTH] total ones of the accepted vector
//   output_valid  out              output_count is valid
//   output_ready  in               downstream takes the result
//   busy          out              a job is counting or awaiting pickup

module count_ones #(
  parameter  int WIDTH    = 8,
  localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [CNT_WIDTH-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CNT_WIDTH'(bits[i]);
    end
  end

endmodule

module count_ones_sequencer #(
  parameter  int WIDTH       = 32,
  parameter  int CHUNK_WIDTH = 8,
  localparam int NUM_CHUNKS  = (WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH,
  localparam int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       input_data,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic [COUNT_WIDTH-1:0] output_count,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic                   busy
);

  localparam int PAD_WIDTH         = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int CHUNK_COUNT_WIDTH = $clog2(CHUNK_WIDTH + 1);
  localparam int INDEX_WIDTH       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] data_q, data_d;
  logic [COUNT_WIDTH-1:0] acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;

  logic [CHUNK_WIDTH-1:0]       chunk;
  logic [CHUNK_COUNT_WIDTH-1:0] chunk_ones;
  logic [COUNT_WIDTH-1:0]       sum;
  logic                         last_chunk;

  // With a single chunk there is nothing to index; select it directly so the
  // index register never addresses a one-entry array.
  if (NUM_CHUNKS == 1) begin : g_one_chunk
    assign chunk = data_q[0];
  end else begin : g_many_chunks
    assign chunk = data_q[index_q];
  end

  count_ones #(
    .WIDTH (CHUNK_WIDTH)
  ) u_count_ones (
    .bits (chunk),
    .ones (chunk_ones)
  );

  assign sum        = acc_q + COUNT_WIDTH'(chunk_ones);
  assign last_chunk = (index_q == LAST_INDEX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (input_valid)  state_d = S_COUNT;
      S_COUNT: if (last_chunk)   state_d = S_DONE;
      S_DONE:  if (output_ready) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    acc_d   = acc_q;
    count_d = count_q;
    index_d = index_q;
    case (state_q)
      S_IDLE: begin
        if (input_valid) begin
          // Zero padding above WIDTH keeps the last chunk's extra bits out of the sum.
          data_d  = PAD_WIDTH'(input_data);
          acc_d   = '0;
          index_d = '0;
        end
      end
      S_COUNT: begin
        acc_d   = sum;
        index_d = index_q + INDEX_WIDTH'(1);
        if (last_chunk) count_d = sum;
      end
      default: ;
    endcase
  end

  // All outputs come from registered state only.
  always_comb begin
    input_ready  = (state_q == S_IDLE);
    output_valid = (state_q == S_DONE);
    busy         = (state_q != S_IDLE);
    output_count = count_q;
  end

endmodule

// File: tb/tb_count_ones_sequencer.sv
// tb/tb_count_ones_sequencer.sv - directed self-checking bench for count_ones_sequencer

module tb_count_ones_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // DUT a: 32/8
  logic [31:0] a_data = '0;
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [5:0]  a_count;
  // DUT b: 10/4
  logic [9:0]  b_data = '0;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [3:0]  b_count;
  // DUT c: 8/8
  logic [7:0]  c_data = '0;
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_busy;
  logic [3:0]  c_count;

  int n_cmp = 0;
  int n_fail = 0;

  count_ones_sequencer #(.WIDTH(32), .CHUNK_WIDTH(8)) dut_a (
    .clock(clock), .reset(reset), .input_data(a_data), .input_valid(a_in_valid),
    .input_ready(a_in_ready), .output_count(a_count), .output_valid(a_out_valid),
    .output_ready(a_out_ready), .busy(a_busy));

  count_ones_sequencer #(.WIDTH(10), .CHUNK_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .input_data(b_data), .input_valid(b_in_valid),
    .input_ready(b_in_ready), .output_count(b_count), .output_valid(b_out_valid),
    .output_ready(b_out_ready), .busy(b_busy));

  count_ones_sequencer #(.WIDTH(8), .CHUNK_WIDTH(8)) dut_c (
    .clock(clock), .reset(reset), .input_data(c_data), .input_valid(c_in_valid),
    .input_ready(c_in_ready), .output_count(c_count), .output_valid(c_out_valid),
    .output_ready(c_out_ready), .busy(c_busy));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_in_ready got=%0b want=1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_out_valid got=%0b want=0", a_out_valid); end
    n_cmp++; if (a_count !== 6'd0) begin n_fail++; $display("FAIL rst_a_count got=%0d want=0", a_count); end
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy got=%0b want=0", a_busy); end
    n_cmp++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_count !== 4'd0) begin
      n_fail++; $display("FAIL rst_b got ready=%0b valid=%0b busy=%0b count=%0d want 1 0 0 0", b_in_ready, b_out_valid, b_busy, b_count); end
    n_cmp++; if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0 || c_busy !== 1'b0 || c_count !== 4'd0) begin
      n_fail++; $display("FAIL rst_c got ready=%0b valid=%0b busy=%0b count=%0d want 1 0 0 0", c_in_ready, c_out_valid, c_busy, c_count); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_full_scale();
    a_data = 32'hFFFF_FFFF; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();  // edge T: handshake
    a_in_valid = 1'b0; a_data = 32'h0;
    n_cmp++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL fs_busy_at_T got=%0b want=1", a_busy); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL fs_in_ready_at_T got=%0b want=0", a_in_ready); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fs_early_valid cycle=%0d got=%0b want=0", k, a_out_valid); end
    end
    tick();  // T+4
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL fs_valid got=%0b want=1", a_out_valid); end
    n_cmp++; if (a_count !== 6'd32) begin n_fail++; $display("FAIL fs_count got=%0d want=32", a_count); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL fs_after_pop got valid=%0b ready=%0b busy=%0b want 0 1 0", a_out_valid, a_in_ready, a_busy); end
    n_cmp++; if (a_count !== 6'd32) begin n_fail++; $display("FAIL fs_count_retained got=%0d want=32", a_count); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    a_data = 32'h0000_0000; a_in_valid = 1'b1;
    tick();  // T1: first handshake
    a_data = 32'h8000_0001;  // held valid; ignored until IDLE returns
    repeat (3) tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid got=%0b want=0", a_out_valid); end
    tick();  // T1+4
    n_cmp++; if (a_out_valid !== 1'b1 || a_count !== 6'd0) begin
      n_fail++; $display("FAIL b2b_first got valid=%0b count=%0d want 1 0", a_out_valid, a_count); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done got=%0b want=0", a_in_ready); end
    tick();  // U: output handshake
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_bubble got ready=%0b valid=%0b want 1 0", a_in_ready, a_out_valid); end
    tick();  // U+1: second input handshake
    a_in_valid = 1'b0; a_data = 32'h0;
    n_cmp++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_accept got ready=%0b busy=%0b want 0 1", a_in_ready, a_busy); end
    repeat (3) tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second_early got=%0b want=0", a_out_valid); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b1 || a_count !== 6'd2) begin
      n_fail++; $display("FAIL b2b_second got valid=%0b count=%0d want 1 2", a_out_valid, a_count); end
    tick();
    a_out_ready = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_end got valid=%0b ready=%0b want 0 1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_stall();
    a_out_ready = 1'b0;
    a_data = 32'h0F0F_00F0; a_in_valid = 1'b1;
    tick();  // T
    for (int k = 0; k < 3; k++) begin
      a_data = 32'hFFFF_FFFF ^ k; a_in_valid = k[0];
      tick();
    end
    a_in_valid = 1'b1; a_data = 32'hFFFF_FFFF;
    tick();  // T+4
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (a_out_valid !== 1'b1 || a_count !== 6'd12 || a_in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold cycle=%0d got valid=%0b count=%0d ready=%0b want 1 12 0", k, a_out_valid, a_count, a_in_ready); end
      a_in_valid = ~a_in_valid; a_data = ~a_data;
      tick();
    end
    n_cmp++; if (a_out_valid !== 1'b1 || a_count !== 6'd12) begin
      n_fail++; $display("FAIL stall_pre_pop got valid=%0b count=%0d want 1 12", a_out_valid, a_count); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_count !== 6'd12) begin
      n_fail++; $display("FAIL stall_pop got valid=%0b ready=%0b count=%0d want 0 1 12", a_out_valid, a_in_ready, a_count); end
    tick();
    a_out_ready = 1'b0;
    n_cmp++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_single_pop got busy=%0b valid=%0b want 0 0", a_busy, a_out_valid); end
  endtask

  task automatic test_padding();
    b_data = 10'h3FF; b_in_valid = 1'b1; b_out_ready = 1'b0;
    tick();  // T
    b_in_valid = 1'b0;
    repeat (2) tick();
    n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL pad_early got=%0b want=0", b_out_valid); end
    tick();  // T+3
    n_cmp++; if (b_out_valid !== 1'b1 || b_count !== 4'd10) begin
      n_fail++; $display("FAIL pad_count got valid=%0b count=%0d want 1 10", b_out_valid, b_count); end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL pad_pop got=%0b want=1", b_in_ready); end
  endtask

  task automatic test_reset_abort();
    int seen;
    a_data = 32'hFFFF_FFFF; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();  // T
    a_in_valid = 1'b0;
    tick();  // T+1, second COUNT cycle in progress
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_count !== 6'd0) begin
      n_fail++; $display("FAIL abort_reset got ready=%0b valid=%0b busy=%0b count=%0d want 1 0 0 0", a_in_ready, a_out_valid, a_busy, a_count); end
    tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (a_out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_valid got=%0d pulses want=0", seen); end
    a_data = 32'h0000_0007; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (a_out_valid !== 1'b1 || a_count !== 6'd3) begin
      n_fail++; $display("FAIL abort_next_job got valid=%0b count=%0d want 1 3", a_out_valid, a_count); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_single_chunk();
    c_data = 8'hA5; c_in_valid = 1'b1; c_out_ready = 1'b0;
    tick();  // T
    c_in_valid = 1'b0;
    n_cmp++; if (c_busy !== 1'b1 || c_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_at_T got busy=%0b valid=%0b want 1 0", c_busy, c_out_valid); end
    tick();  // T+1
    n_cmp++; if (c_out_valid !== 1'b1 || c_count !== 4'd4) begin
      n_fail++; $display("FAIL single_count got valid=%0b count=%0d want 1 4", c_out_valid, c_count); end
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
    n_cmp++; if (c_in_ready !== 1'b1 || c_count !== 4'd4) begin
      n_fail++; $display("FAIL single_pop got ready=%0b count=%0d want 1 4", c_in_ready, c_count); end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_back_to_back();
    test_stall();
    test_padding();
    test_reset_abort();
    test_single_chunk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
